axi_wr_burst_split: RTL and testbench



---
 rtl/axi_split_pkg.sv | 111 +++++++++++
 rtl/axi_wr_split_addr_gen.sv | 20 ++
 rtl/axi_wr_burst_split.sv | 152 +++++++++++++++
 tb/tb_axi_wr_burst_split.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_split_pkg.sv
// axi_split_pkg: AXI channel types, FSM states and helpers shared by
// the write burst splitter and its address generator.
package axi_split_pkg;

  localparam int IdW   = 4;
  localparam int AddrW = 64;
  localparam int DataW = 64;
  localparam int StrbW = DataW / 8;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExOkay = 2'b01;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [1:0] {IDLE, SPLIT, RESP} split_state_e;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic             lock;
    logic [3:0]       cache;
    logic [2:0]       prot;
    logic [3:0]       qos;
  } aw_t;

  typedef aw_t ar_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [StrbW-1:0] strb;
    logic             last;
  } w_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } b_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
  } r_t;

  typedef struct packed {
    aw_t  aw;
    logic aw_valid;
    w_t   w;
    logic w_valid;
    logic b_ready;
    ar_t  ar;
    logic ar_valid;
    logic r_ready;
  } req_t;

  typedef struct packed {
    logic aw_ready;
    logic w_ready;
    b_t   b;
    logic b_valid;
    logic ar_ready;
    r_t   r;
    logic r_valid;
  } resp_t;

  // Address of beat idx within a burst; wraps modulo 2^AddrW.
  function automatic logic [AddrW-1:0] beat_addr(
    input logic [AddrW-1:0] base,
    input logic [AddrW-1:0] idx,
    input logic [7:0]       len,
    input logic [2:0]       size,
    input logic [1:0]       burst
  );
    logic [AddrW-1:0] nxt;
    logic [AddrW-1:0] mask;
    nxt  = base + (idx << size);
    mask = ((AddrW'(len) + AddrW'(1)) << size) - AddrW'(1);
    case (burst)
      BurstFixed: beat_addr = base;
      BurstWrap:  beat_addr = (base & ~mask) | (nxt & mask);
      default:    beat_addr = nxt;
    endcase
  endfunction

  // Worst of two responses: DECERR > SLVERR > OKAY (EXOKAY counts as OKAY).
  function automatic logic [1:0] resp_merge(
    input logic [1:0] a,
    input logic [1:0] b
  );
    logic [1:0] ra;
    logic [1:0] rb;
    logic [1:0] rm;
    ra = (a == RespDecErr) ? 2'd2 : (a == RespSlvErr) ? 2'd1 : 2'd0;
    rb = (b == RespDecErr) ? 2'd2 : (b == RespSlvErr) ? 2'd1 : 2'd0;
    rm = (ra > rb) ? ra : rb;
    case (rm)
      2'd2:    resp_merge = RespDecErr;
      2'd1:    resp_merge = RespSlvErr;
      default: resp_merge = RespOkay;
    endcase
  endfunction

endpackage

// File: rtl/axi_wr_split_addr_gen.sv
// axi_wr_split_addr_gen: combinational per-beat address for a split
// burst (FIXED / INCR / WRAP); shared with a future read splitter.
module axi_wr_split_addr_gen
  import axi_split_pkg::*;
#(
  parameter int AddrWidth = 64,
  parameter int CntW      = 9
) (
  input  logic [AddrWidth-1:0] base,
  input  logic [CntW-1:0]      idx,
  input  logic [7:0]           len,
  input  logic [2:0]           size,
  input  logic [1:0]           burst,
  output logic [AddrWidth-1:0] addr
);

  assign addr = AddrWidth'(beat_addr(
    AddrW'(base), AddrW'(idx), len, size, burst));

endmodule

// File: rtl/axi_wr_burst_split.sv
// axi_wr_burst_split: splits one upstream write burst into single-beat
// writes and folds the B responses. Option: AXI_WR_SPLIT_RESP_MERGE_EN.
module axi_wr_burst_split
  import axi_split_pkg::*;
#(
  parameter int  MaxBeats   = 256,
  parameter int  AddrWidth  = 64,
  parameter type aw_chan_t  = aw_t,
  parameter type w_chan_t   = w_t,
  parameter type b_chan_t   = b_t,
  parameter type ar_chan_t  = ar_t,
  parameter type r_chan_t   = r_t,
  parameter type axi_req_t  = req_t,
  parameter type axi_resp_t = resp_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i
);

  localparam int CntW = $clog2(MaxBeats + 1);

  split_state_e         state;
  aw_chan_t             aw_q;
  logic [CntW-1:0]      aw_cnt;
  logic [CntW-1:0]      w_cnt;
  logic [CntW-1:0]      b_cnt;
  logic [CntW-1:0]      b_cnt_nxt;
  logic [CntW-1:0]      len_p1;
  logic [1:0]           resp_acc;
  logic [AddrWidth-1:0] addr_beat;
  logic                 w_open;
  logic                 aw_hs;
  logic                 w_hs;
  logic                 b_hs;
  aw_chan_t             aw_fwd;
  w_chan_t              w_fwd;
  b_chan_t              b_up;
  ar_chan_t             ar_fwd;
  r_chan_t              r_fwd;
  logic                 unused_b_id;

  assign unused_b_id = ^mst_resp_i.b.id;

  assign len_p1    = CntW'(aw_q.len) + CntW'(1);
  assign w_open    = (state == SPLIT) && (w_cnt < aw_cnt);
  assign aw_hs     = mst_req_o.aw_valid && mst_resp_i.aw_ready;
  assign w_hs      = mst_req_o.w_valid && mst_resp_i.w_ready;
  assign b_hs      = mst_req_o.b_ready && mst_resp_i.b_valid;
  assign b_cnt_nxt = b_cnt + CntW'(b_hs);

  axi_wr_split_addr_gen #(
    .AddrWidth(AddrWidth),
    .CntW     (CntW)
  ) u_addr_gen (
    .base (AddrWidth'(aw_q.addr)),
    .idx  (aw_cnt),
    .len  (aw_q.len),
    .size (aw_q.size),
    .burst(aw_q.burst),
    .addr (addr_beat)
  );

  // Port drive: single-beat AW/W downstream, one B upstream, AR/R wired.
  always_comb begin
    aw_fwd       = aw_q;
    aw_fwd.addr  = AddrW'(addr_beat);
    aw_fwd.len   = '0;
    aw_fwd.burst = BurstIncr;
    w_fwd        = slv_req_i.w;
    w_fwd.last   = 1'b1;
    b_up         = '0;
    b_up.id      = aw_q.id;
    b_up.resp    = resp_acc;
    ar_fwd       = slv_req_i.ar;
    r_fwd        = mst_resp_i.r;

    mst_req_o          = '0;
    mst_req_o.aw       = aw_fwd;
    mst_req_o.aw_valid = (state == SPLIT) && (aw_cnt < len_p1);
    mst_req_o.w        = w_fwd;
    mst_req_o.w_valid  = slv_req_i.w_valid && w_open;
    mst_req_o.b_ready  = (state == SPLIT);
    mst_req_o.ar       = ar_fwd;
    mst_req_o.ar_valid = slv_req_i.ar_valid;
    mst_req_o.r_ready  = slv_req_i.r_ready;

    slv_resp_o          = '0;
    slv_resp_o.aw_ready = (state == IDLE);
    slv_resp_o.w_ready  = mst_resp_i.w_ready && w_open;
    slv_resp_o.b        = b_up;
    slv_resp_o.b_valid  = (state == RESP);
    slv_resp_o.ar_ready = mst_resp_i.ar_ready;
    slv_resp_o.r        = r_fwd;
    slv_resp_o.r_valid  = mst_resp_i.r_valid;
  end

  // Burst sequencing: capture AW, count AW/W/B beats, return one B.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      aw_q     <= '0;
      aw_cnt   <= '0;
      w_cnt    <= '0;
      b_cnt    <= '0;
      resp_acc <= RespOkay;
    end else begin
      unique case (state)
        IDLE: begin
          if (slv_req_i.aw_valid) begin
            aw_q  <= slv_req_i.aw;
            state <= SPLIT;
          end
        end
        SPLIT: begin
          if (aw_hs) aw_cnt <= aw_cnt + CntW'(1);
          if (w_hs)  w_cnt  <= w_cnt + CntW'(1);
          if (b_hs) begin
            b_cnt <= b_cnt_nxt;
`ifdef AXI_WR_SPLIT_RESP_MERGE_EN
            resp_acc <= resp_merge(resp_acc, mst_resp_i.b.resp);
`else
            resp_acc <= mst_resp_i.b.resp;
`endif
          end
          if (b_cnt_nxt == len_p1) state <= RESP;
        end
        RESP: begin
          if (slv_req_i.b_ready) begin
            state    <= IDLE;
            aw_cnt   <= '0;
            w_cnt    <= '0;
            b_cnt    <= '0;
            resp_acc <= RespOkay;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Upstream WLAST must coincide with the beat the counters treat as last.
  wlast_check: assert property (@(posedge clk_i) disable iff (rst_i)
    (slv_req_i.w_valid && slv_resp_o.w_ready)
      |-> (slv_req_i.w.last == (w_cnt == CntW'(aw_q.len))));
`endif

endmodule

// File: tb/tb_axi_wr_burst_split.sv
// tb_axi_wr_burst_split: scoreboard bench for the write burst splitter.
// Expected AW/W/B values are queued at stimulus time, checked on handshake.
`timescale 1ns/1ps
module tb_axi_wr_burst_split;
  import axi_split_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  req_t  slv_req;
  resp_t slv_resp;
  req_t  mst_req;
  resp_t mst_resp;

  int n_tests = 0;
  int n_fail  = 0;

  aw_t         exp_aw_q[$];
  logic [63:0] exp_w_q[$];
  b_t          exp_b_q[$];
  logic [1:0]  ds_b_q[$];
  int aw_seen  = 0;
  int w_seen   = 0;
  int err_beat = -1;

  logic        ds_aw_block = 1'b0;
  logic        ds_aw_ready = 1'b1;
  logic        ds_b_valid  = 1'b0;
  logic [1:0]  ds_b_resp   = RespOkay;
  logic        ds_ar_ready = 1'b0;
  logic        ds_r_valid  = 1'b0;
  logic [63:0] ds_r_data   = '0;

  always #5 clk = ~clk;

  axi_wr_burst_split dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .slv_req_i (slv_req),
    .slv_resp_o(slv_resp),
    .mst_req_o (mst_req),
    .mst_resp_i(mst_resp)
  );

  always_comb begin
    mst_resp          = '0;
    mst_resp.aw_ready = ds_aw_ready;
    mst_resp.w_ready  = 1'b1;
    mst_resp.b_valid  = ds_b_valid;
    mst_resp.b.resp   = ds_b_resp;
    mst_resp.ar_ready = ds_ar_ready;
    mst_resp.r_valid  = ds_r_valid;
    mst_resp.r.data   = ds_r_data;
  end

  // Downstream slave model: one B per accepted W, one cycle later.
  always begin
    @(posedge clk);
    #2;
    if (rst) ds_b_q.delete();
    ds_aw_ready = !ds_aw_block;
    ds_b_valid  = ds_b_q.size() > 0;
    ds_b_resp   = (ds_b_q.size() > 0) ? ds_b_q[0] : RespOkay;
  end

  aw_t         m_aw;
  logic [63:0] m_w;
  b_t          m_b;

  // Scoreboard: inspect every handshake that the next posedge commits.
  always @(negedge clk) begin
    if (!rst) begin
      if (mst_req.aw_valid && mst_resp.aw_ready) begin
        n_tests++;
        if (exp_aw_q.size() == 0) begin
          n_fail++;
          $display("FAIL aw_extra: got addr %h, required no AW",
                   mst_req.aw.addr);
        end else begin
          m_aw = exp_aw_q.pop_front();
          if (mst_req.aw !== m_aw) begin
            n_fail++;
            $display("FAIL aw_beat%0d: got addr %h len %0d burst %0d, required addr %h len 0 burst 1",
                     aw_seen, mst_req.aw.addr, mst_req.aw.len,
                     mst_req.aw.burst, m_aw.addr);
          end
        end
        aw_seen++;
      end
      if (mst_req.w_valid && mst_resp.w_ready) begin
        n_tests++;
        m_w = (exp_w_q.size() > 0) ? exp_w_q.pop_front() : 64'hx;
        if (mst_req.w.data !== m_w || mst_req.w.last !== 1'b1
            || aw_seen <= w_seen) begin
          n_fail++;
          $display("FAIL w_beat%0d: got data %h last %b aws %0d, required data %h last 1 aws>%0d",
                   w_seen, mst_req.w.data, mst_req.w.last, aw_seen,
                   m_w, w_seen);
        end
        ds_b_q.push_back((w_seen == err_beat) ? RespSlvErr : RespOkay);
        w_seen++;
      end
      if (mst_req.b_ready && mst_resp.b_valid)
        void'(ds_b_q.pop_front());
      if (slv_resp.b_valid && slv_req.b_ready) begin
        n_tests++;
        if (exp_b_q.size() == 0) begin
          n_fail++;
          $display("FAIL b_extra: got id %0d resp %0d, required no B",
                   slv_resp.b.id, slv_resp.b.resp);
        end else begin
          m_b = exp_b_q.pop_front();
          if (slv_resp.b !== m_b) begin
            n_fail++;
            $display("FAIL b_resp: got id %0d resp %0d, required id %0d resp %0d",
                     slv_resp.b.id, slv_resp.b.resp, m_b.id, m_b.resp);
          end
        end
      end
    end
  end

  function automatic logic [63:0] model_addr(
    input logic [63:0] a, input int i, input int len,
    input int size, input logic [1:0] burst);
    logic [63:0] bytes;
    logic [63:0] total;
    logic [63:0] lo;
    bytes = 64'd1 << size;
    total = 64'(len + 1) * bytes;
    if (burst == BurstFixed) return a;
    if (burst == BurstIncr) return a + 64'(i) * bytes;
    lo = a - (a % total);
    return lo + ((a - lo + 64'(i) * bytes) % total);
  endfunction

  function automatic aw_t mk_aw(
    input int id, input logic [63:0] addr, input int len,
    input int size, input logic [1:0] burst);
    aw_t a;
    a       = '0;
    a.id    = 4'(id);
    a.addr  = addr;
    a.len   = 8'(len);
    a.size  = 3'(size);
    a.burst = burst;
    a.cache = 4'h3;
    a.prot  = 3'h2;
    a.qos   = 4'(id + 1);
    return a;
  endfunction

  task automatic prep(input aw_t a, input int err);
    aw_t e;
    b_t  eb;
    int  len;
    len      = int'(a.len);
    err_beat = err;
    aw_seen  = 0;
    w_seen   = 0;
    for (int i = 0; i <= len; i++) begin
      e       = a;
      e.addr  = model_addr(a.addr, i, len, int'(a.size), a.burst);
      e.len   = 8'd0;
      e.burst = BurstIncr;
      exp_aw_q.push_back(e);
      exp_w_q.push_back(64'hA5A5_0000_0000_0000
                        | (64'(a.id) << 16) | 64'(i));
    end
    eb    = '0;
    eb.id = a.id;
`ifdef AXI_WR_SPLIT_RESP_MERGE_EN
    eb.resp = (err >= 0 && err <= len) ? RespSlvErr : RespOkay;
`else
    eb.resp = (err == len) ? RespSlvErr : RespOkay;
`endif
    exp_b_q.push_back(eb);
  endtask

  task automatic drive_aw(input aw_t a);
    bit ok;
    ok = 1'b0;
    slv_req.aw       = a;
    slv_req.aw_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = slv_resp.aw_ready;
      @(posedge clk); #1;
    end
    slv_req.aw_valid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL aw_timeout: aw_ready stayed 0, required 1");
    end
  endtask

  task automatic drive_w(input aw_t a);
    bit ok;
    for (int i = 0; i <= int'(a.len); i++) begin
      ok = 1'b0;
      slv_req.w_valid = 1'b1;
      slv_req.w.data  = 64'hA5A5_0000_0000_0000
                        | (64'(a.id) << 16) | 64'(i);
      slv_req.w.strb  = '1;
      slv_req.w.last  = (i == int'(a.len));
      for (int k = 0; k < 200 && !ok; k++) begin
        @(negedge clk);
        ok = slv_resp.w_ready;
        @(posedge clk); #1;
      end
      if (!ok) begin
        n_tests++; n_fail++;
        $display("FAIL w_timeout: beat %0d w_ready 0, required 1", i);
        break;
      end
    end
    slv_req.w_valid = 1'b0;
    slv_req.w.last  = 1'b0;
  endtask

  task automatic wait_b();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = slv_resp.b_valid;
      @(posedge clk); #1;
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL b_timeout: b_valid 0, required 1");
    end else begin
      slv_req.b_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      slv_req.b_ready = 1'b0;
    end
  endtask

  task automatic burst(input aw_t a, input int err);
    prep(a, err);
    drive_aw(a);
    drive_w(a);
    wait_b();
  endtask

  task automatic test_reset();
    slv_req = '0;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (slv_resp.aw_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_aw_ready: got %b, required 1", slv_resp.aw_ready);
    end
    n_tests++;
    if (slv_resp.b_valid !== 1'b0 || slv_resp.w_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_slv: got b_valid %b w_ready %b, required 0 0",
               slv_resp.b_valid, slv_resp.w_ready);
    end
    n_tests++;
    if (mst_req.aw_valid !== 1'b0 || mst_req.w_valid !== 1'b0
        || mst_req.b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mst: got aw_v %b w_v %b b_rdy %b, required 0 0 0",
               mst_req.aw_valid, mst_req.w_valid, mst_req.b_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_incr();
    aw_t a;
    a = mk_aw(5, 64'h1000, 3, 3, BurstIncr);
    prep(a, -1);
    drive_aw(a);
    @(negedge clk);
    n_tests++;
    if (mst_req.aw_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL aw_latency: mst aw_valid %b, required 1",
               mst_req.aw_valid);
    end
    @(posedge clk); #1;
    drive_w(a);
    wait_b();
    n_tests++;
    if (exp_aw_q.size() + exp_w_q.size() + exp_b_q.size() != 0) begin
      n_fail++;
      $display("FAIL incr_drain: got %0d left, required 0",
               exp_aw_q.size() + exp_w_q.size() + exp_b_q.size());
    end
  endtask

  task automatic test_wrap();
    burst(mk_aw(6, 64'h1018, 3, 3, BurstWrap), -1);
    burst(mk_aw(7, 64'h2034, 7, 2, BurstWrap), -1);
    n_tests++;
    if (exp_aw_q.size() + exp_w_q.size() + exp_b_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_drain: got %0d left, required 0",
               exp_aw_q.size() + exp_w_q.size() + exp_b_q.size());
    end
  endtask

  task automatic test_fixed_len0();
    burst(mk_aw(8, 64'h2004, 2, 2, BurstFixed), -1);
    burst(mk_aw(9, 64'h3000, 0, 2, BurstIncr), -1);
    burst(mk_aw(10, 64'hFFFF_FFFF_FFFF_FFF0, 3, 3, BurstIncr), -1);
    n_tests++;
    if (exp_aw_q.size() + exp_w_q.size() + exp_b_q.size() != 0) begin
      n_fail++;
      $display("FAIL fixed_drain: got %0d left, required 0",
               exp_aw_q.size() + exp_w_q.size() + exp_b_q.size());
    end
  endtask

  task automatic test_err();
    burst(mk_aw(11, 64'h4000, 3, 3, BurstIncr), 1);
    burst(mk_aw(12, 64'h5000, 3, 3, BurstIncr), 3);
    burst(mk_aw(13, 64'h6000, 0, 3, BurstIncr), 0);
    n_tests++;
    if (exp_b_q.size() != 0) begin
      n_fail++;
      $display("FAIL err_drain: got %0d B left, required 0",
               exp_b_q.size());
    end
  endtask

  task automatic test_aw_stall();
    aw_t a;
    a = mk_aw(3, 64'h7000, 3, 3, BurstIncr);
    prep(a, -1);
    ds_aw_block = 1'b1;
    @(posedge clk); #1;
    drive_aw(a);
    slv_req.w_valid = 1'b1;
    slv_req.w.data  = 64'hA5A5_0000_0003_0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (mst_req.w_valid !== 1'b0 || slv_resp.w_ready !== 1'b0
          || mst_req.aw_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL aw_stall%0d: got mst w_v %b slv w_rdy %b aw_v %b, required 0 0 1",
                 k, mst_req.w_valid, slv_resp.w_ready, mst_req.aw_valid);
      end
      @(posedge clk); #1;
    end
    ds_aw_block = 1'b0;
    drive_w(a);
    wait_b();
    n_tests++;
    if (exp_aw_q.size() + exp_w_q.size() + exp_b_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_drain: got %0d left, required 0",
               exp_aw_q.size() + exp_w_q.size() + exp_b_q.size());
    end
  endtask

  task automatic test_b_stall();
    aw_t a;
    bit  seen;
    a = mk_aw(14, 64'h8000, 1, 3, BurstIncr);
    prep(a, 0);
    drive_aw(a);
    drive_w(a);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = slv_resp.b_valid;
      @(posedge clk); #1;
    end
    slv_req.aw       = mk_aw(15, 64'h9000, 0, 3, BurstIncr);
    slv_req.aw_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (slv_resp.b_valid !== 1'b1 || slv_resp.b !== exp_b_q[0]
          || slv_resp.aw_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL b_hold%0d: got b_v %b resp %0d aw_rdy %b, required 1 %0d 0",
                 k, slv_resp.b_valid, slv_resp.b.resp,
                 slv_resp.aw_ready, exp_b_q[0].resp);
      end
      @(posedge clk); #1;
    end
    slv_req.aw_valid = 1'b0;
    slv_req.b_ready  = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    slv_req.b_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (slv_resp.aw_ready !== 1'b1 || slv_resp.b_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b_release: got aw_rdy %b b_v %b, required 1 0",
               slv_resp.aw_ready, slv_resp.b_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ar_r();
    ar_t ar;
    ar = mk_aw(2, 64'h1234_5678_9ABC_DEF0, 7, 3, BurstWrap);
    slv_req.ar       = ar;
    slv_req.ar_valid = 1'b1;
    slv_req.r_ready  = 1'b1;
    ds_ar_ready      = 1'b1;
    ds_r_valid       = 1'b1;
    ds_r_data        = 64'hCAFE_F00D_0000_0001;
    @(negedge clk);
    n_tests++;
    if (mst_req.ar !== ar || mst_req.ar_valid !== 1'b1
        || mst_req.r_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_pass: got addr %h v %b rr %b, required %h 1 1",
               mst_req.ar.addr, mst_req.ar_valid, mst_req.r_ready, ar.addr);
    end
    n_tests++;
    if (slv_resp.r.data !== 64'hCAFE_F00D_0000_0001
        || slv_resp.r_valid !== 1'b1 || slv_resp.ar_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL r_pass: got data %h v %b ar_rdy %b, required cafef00d00000001 1 1",
               slv_resp.r.data, slv_resp.r_valid, slv_resp.ar_ready);
    end
    @(posedge clk); #1;
    slv_req.ar_valid = 1'b0;
    slv_req.r_ready  = 1'b0;
    ds_ar_ready      = 1'b0;
    ds_r_valid       = 1'b0;
  endtask

  task automatic test_reset_mid();
    aw_t a;
    a = mk_aw(4, 64'hA000, 3, 3, BurstIncr);
    prep(a, -1);
    drive_aw(a);
    for (int k = 0; k < 50 && aw_seen < 2; k++) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (aw_seen != 2) begin
      n_fail++;
      $display("FAIL mid_aw_count: got %0d AWs, required 2", aw_seen);
    end
    rst = 1'b1;
    exp_aw_q.delete();
    exp_w_q.delete();
    exp_b_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (slv_resp.aw_ready !== 1'b1 || mst_req.aw_valid !== 1'b0
        || mst_req.w_valid !== 1'b0 || mst_req.b_ready !== 1'b0
        || slv_resp.b_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got aw_rdy %b aw_v %b w_v %b b_rdy %b b_v %b, required 1 0 0 0 0",
               slv_resp.aw_ready, mst_req.aw_valid, mst_req.w_valid,
               mst_req.b_ready, slv_resp.b_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int          len;
    int          size;
    logic [1:0]  bt;
    logic [63:0] addr;
    int          lens[4];
    lens = '{1, 3, 7, 15};
    burst(mk_aw(1, 64'hB000, 1, 3, BurstIncr), -1);
    for (int j = 0; j < 6; j++) begin
      bt   = 2'($urandom_range(0, 2));
      len  = (bt == BurstWrap) ? lens[$urandom_range(0, 3)]
                               : int'($urandom_range(0, 9));
      size = int'($urandom_range(0, 3));
      addr = {32'($urandom), 32'($urandom)};
      burst(mk_aw(j + 2, addr, len, size, bt),
            int'($urandom_range(0, 12)) - 2);
    end
    n_tests++;
    if (exp_aw_q.size() + exp_w_q.size() + exp_b_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: got %0d left, required 0",
               exp_aw_q.size() + exp_w_q.size() + exp_b_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_fixed_len0();
    test_err();
    test_aw_stall();
    test_b_stall();
    test_ar_r();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
